// File: rtl/simmem_rsp_bank_pool.sv
// simmem_rsp_bank_pool: per-channel response slot pool (reserve by ID, in-order fill per ID, released slots drained by arbitration).
module simmem_rsp_bank_pool #(
    parameter int TotCapa = 8,
    parameter int NumIds  = 4,
    parameter int DataW   = 16,
    parameter int ArbMode = 0,
    localparam int SlotW  = $clog2(TotCapa),
    localparam int IdW    = $clog2(NumIds)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IdW-1:0]     rsv_id_i,
    input  logic               rsv_valid_i,
    output logic               rsv_ready_o,
    output logic [SlotW-1:0]   rsv_iid_o,
    input  logic [DataW-1:0]   in_rsp_i,
    input  logic [IdW-1:0]     in_rsp_id_i,
    input  logic               in_rsp_valid_i,
    output logic               in_rsp_ready_o,
    input  logic [TotCapa-1:0] release_en_i,
    output logic [DataW-1:0]   out_rsp_o,
    output logic               out_rsp_valid_o,
    input  logic               out_rsp_ready_i,
    output logic [TotCapa-1:0] released_onehot_o,
    output logic [SlotW:0]     occupancy_o
);
    typedef enum logic [1:0] {FREE, RSVD, FILLED, RELD} slot_st_e;

    slot_st_e         r_st       [TotCapa];
    logic [IdW-1:0]   r_id       [TotCapa];
    logic [SlotW:0]   r_seq      [TotCapa];
    logic [DataW-1:0] r_data     [TotCapa];
    logic [SlotW:0]   r_rsv_seq  [NumIds];
    logic [SlotW:0]   r_fill_seq [NumIds];
    logic             r_lock;
    logic [SlotW-1:0] r_lock_idx, r_rr;
    logic [SlotW:0]   r_occ;

    logic             w_free_any, w_fill_hit, w_any, w_rsv, w_fill, w_hs;
    logic [SlotW-1:0] w_alloc, w_fill_idx, w_sel, w_j;

    always_comb begin
        w_free_any = 1'b0;
        w_alloc = '0;
        for (int i = TotCapa-1; i >= 0; i--)
            if (r_st[i] == FREE) begin
                w_free_any = 1'b1;
                w_alloc = SlotW'(i);
            end
    end

    // the oldest outstanding reservation of an ID is the one whose seq equals that ID's fill counter
    always_comb begin
        w_fill_hit = 1'b0;
        w_fill_idx = '0;
        for (int i = TotCapa-1; i >= 0; i--)
            if (r_st[i] == RSVD && r_id[i] == in_rsp_id_i && r_seq[i] == r_fill_seq[in_rsp_id_i]) begin
                w_fill_hit = 1'b1;
                w_fill_idx = SlotW'(i);
            end
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_j = '0;
        for (int k = TotCapa-1; k >= 0; k--) begin
            w_j = SlotW'((ArbMode == 0) ? k : (int'(r_rr) + k) % TotCapa);
            if (r_st[w_j] == RELD) begin
                w_any = 1'b1;
                w_sel = w_j;
            end
        end
        w_sel = r_lock ? r_lock_idx : w_sel;
    end

    assign w_rsv             = rsv_valid_i & w_free_any;
    assign w_fill            = in_rsp_valid_i & w_fill_hit;
    assign w_hs              = w_any & out_rsp_ready_i;
    assign rsv_ready_o       = w_free_any;
    assign rsv_iid_o         = w_alloc;
    assign in_rsp_ready_o    = w_fill_hit;
    assign out_rsp_valid_o   = w_any;
    assign out_rsp_o         = w_any ? r_data[w_sel] : '0;
    assign released_onehot_o = w_hs ? (TotCapa'(1) << w_sel) : '0;
    assign occupancy_o       = r_occ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TotCapa; i++) r_st[i] <= FREE;
            for (int i = 0; i < NumIds; i++) begin
                r_rsv_seq[i] <= '0;
                r_fill_seq[i] <= '0;
            end
            r_lock <= 1'b0;
            r_lock_idx <= '0;
            r_rr <= '0;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < TotCapa; i++)
                if (r_st[i] == FILLED && release_en_i[i]) r_st[i] <= RELD;
            if (w_rsv) begin
                r_st[w_alloc] <= RSVD;
                r_id[w_alloc] <= rsv_id_i;
                r_seq[w_alloc] <= r_rsv_seq[rsv_id_i];
                r_rsv_seq[rsv_id_i] <= r_rsv_seq[rsv_id_i] + 1'b1;
            end
            if (w_fill) begin
                r_st[w_fill_idx] <= FILLED;
                r_data[w_fill_idx] <= in_rsp_i;
                r_fill_seq[in_rsp_id_i] <= r_fill_seq[in_rsp_id_i] + 1'b1;
            end
            if (w_hs) begin
                r_st[w_sel] <= FREE;
                r_lock <= 1'b0;
                if (ArbMode != 0) r_rr <= (w_sel == SlotW'(TotCapa-1)) ? '0 : w_sel + 1'b1;
            end else if (w_any) begin
                r_lock <= 1'b1;
                r_lock_idx <= w_sel;
            end
            r_occ <= r_occ + (SlotW+1)'(w_rsv) - (SlotW+1)'(w_hs);
        end
    end
endmodule
